fetch_pc_gen_way1: RTL and testbench

//   Upstream address generator for the way-1 instruction fetch stage. Produces
//   the way-1 fetch address stream (pair base + WAY_OFFSET) and issues requests
//   to instruction memory. Tracks outstanding requests and applies backpressure.
//   On a jump it redirects the stream and marks stale in-flight responses for

---
 rtl/fetch_pc_gen_way1.sv | 116 +++++++++++
 tb/tb_fetch_pc_gen_way1.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen_way1.sv
// Way-1 fetch address generator: issues requests and tracks in-flight count.
// Marks stale responses for drop after a redirect. `FETCH_PERF_CNT_EN adds perf counters.
module fetch_pc_gen_way1 #(
  parameter logic [31:0] RESET_PC        = 32'h8000_0000,
  parameter int unsigned ADDR_STRIDE     = 8,
  parameter int unsigned WAY_OFFSET      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic        jumpFlag_i,
  input  logic [31:0] jumpAddr_i,
  input  logic        req_ready_i,
  input  logic        dataOk_i,
  output logic        request_o,
  output logic [31:0] instAddr_o,
  output logic        dataOk_o,
  output logic        drop_o,
  output logic [3:0]  outstanding_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_issue_o,
  output logic [31:0] perf_drop_o
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;

  localparam logic [3:0]  MAX_CNT = 4'(MAX_OUTSTANDING);
  localparam logic [31:0] STRIDE  = 32'(ADDR_STRIDE);
  localparam logic [31:0] OFFSET  = 32'(WAY_OFFSET);

  state_t      state, state_next;
  logic [31:0] pc_base;
  logic [3:0]  outstanding;
  logic [3:0]  kill_cnt;
  logic        resp_valid;
  logic        hold;
  logic        jump_acc;
  logic        issue;
  logic        unused_jump_low;

  assign unused_jump_low = ^jumpAddr_i[2:0];

  // Responses with nothing in flight are spurious and ignored entirely.
  assign resp_valid = dataOk_i & (outstanding != '0);
  assign hold       = stall_i | ((outstanding >= MAX_CNT) & ~resp_valid);
  assign jump_acc   = jumpFlag_i & (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   state_next = hold ? STALL : FETCH;
      STALL:   state_next = hold ? STALL : FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    request_o     = (state == FETCH) & ~jumpFlag_i & ~stall_i &
                    ((outstanding < MAX_CNT) | resp_valid);
    issue         = request_o & req_ready_i;
    drop_o        = resp_valid & (kill_cnt != '0);
    dataOk_o      = resp_valid & ~drop_o;
    instAddr_o    = pc_base + OFFSET;
    outstanding_o = outstanding;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_base     <= RESET_PC;
      outstanding <= '0;
      kill_cnt    <= '0;
    end else begin
      if (jump_acc) begin
        pc_base <= {jumpAddr_i[31:3], 3'b000};
      end else if (issue) begin
        pc_base <= pc_base + STRIDE;
      end
      outstanding <= outstanding + 4'(issue) - 4'(resp_valid);
      // On a redirect every request still in flight after this cycle's response is stale.
      if (jump_acc) begin
        kill_cnt <= outstanding - 4'(resp_valid);
      end else if (drop_o) begin
        kill_cnt <= kill_cnt - 4'd1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_issue_o <= '0;
      perf_drop_o  <= '0;
    end else begin
      if (issue && (perf_issue_o != '1)) begin
        perf_issue_o <= perf_issue_o + 32'd1;
      end
      if (drop_o && (perf_drop_o != '1)) begin
        perf_drop_o <= perf_drop_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_gen_way1.sv
// Scoreboard bench for fetch_pc_gen_way1: a queue-based request/response model
// predicts every cycle's outputs; a negedge monitor pops and compares.
module tb_fetch_pc_gen_way1;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          MAX      = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_i, jumpFlag_i, req_ready_i, dataOk_i;
  logic [31:0] jumpAddr_i;
  logic        request_o, dataOk_o, drop_o;
  logic [31:0] instAddr_o;
  logic [3:0]  outstanding_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_issue_o, perf_drop_o;
`endif

  fetch_pc_gen_way1 #(
    .RESET_PC(RESET_PC), .ADDR_STRIDE(8), .WAY_OFFSET(4), .MAX_OUTSTANDING(MAX)
  ) dut (
    .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .jumpFlag_i(jumpFlag_i),
    .jumpAddr_i(jumpAddr_i), .req_ready_i(req_ready_i), .dataOk_i(dataOk_i),
    .request_o(request_o), .instAddr_o(instAddr_o), .dataOk_o(dataOk_o),
    .drop_o(drop_o), .outstanding_o(outstanding_o)
`ifdef FETCH_PERF_CNT_EN
    , .perf_issue_o(perf_issue_o), .perf_drop_o(perf_drop_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        ok;
    logic        drop;
    logic [3:0]  out;
    logic [31:0] pi;
    logic [31:0] pd;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] issue_log[$];
  int          checks = 0;
  int          errors = 0;
  int          dut_drops = 0;
  int          dut_oks = 0;

  // Reference model: in-flight requests are a FIFO of stale flags.
  bit          m_started, m_fetching;
  logic [31:0] m_pc, m_pi, m_pd;
  bit          m_inflight[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_fetching = 0; m_pc = RESET_PC;
    m_inflight.delete(); m_pi = '0; m_pd = '0;
  endtask

  task automatic drive(input bit st, input bit jf, input logic [31:0] ja,
                       input bit rdy, input bit dok);
    exp_t e;
    int   n;
    bit   resp, issue, front;
    stall_i = st; jumpFlag_i = jf; jumpAddr_i = ja; req_ready_i = rdy; dataOk_i = dok;
    n     = m_inflight.size();
    resp  = dok && (n > 0);
    front = resp ? m_inflight[0] : 1'b0;
    e.req  = m_fetching && !jf && !st && ((n < MAX) || resp);
    e.addr = m_pc + 32'd4;
    e.drop = resp && front;
    e.ok   = resp && !front;
    e.out  = 4'(n);
    e.pi   = m_pi;
    e.pd   = m_pd;
    expq.push_back(e);
    issue = e.req && rdy;
    if (resp) void'(m_inflight.pop_front());
    if (jf && m_started) begin
      foreach (m_inflight[i]) m_inflight[i] = 1'b1;
      m_pc = {ja[31:3], 3'b000};
    end
    if (issue) begin
      m_inflight.push_back(1'b0);
      m_pc = m_pc + 32'd8;
      if (m_pi != 32'hFFFF_FFFF) m_pi = m_pi + 32'd1;
    end
    if (e.drop && (m_pd != 32'hFFFF_FFFF)) m_pd = m_pd + 32'd1;
    m_fetching = m_started ? (!st && !((n >= MAX) && !resp)) : 1'b1;
    m_started  = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic reset_dut(input int cycles);
    exp_t e;
    reset_n = 1'b0;
    model_reset();
    stall_i = 0; jumpFlag_i = 0; jumpAddr_i = '0; req_ready_i = 1; dataOk_i = 1;
    e = '{req: 1'b0, addr: RESET_PC + 32'd4, ok: 1'b0, drop: 1'b0, out: 4'd0, pi: '0, pd: '0};
    repeat (cycles) begin
      expq.push_back(e);
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("request_o",     32'(request_o),     32'(e.req));
      chk("instAddr_o",    instAddr_o,         e.addr);
      chk("dataOk_o",      32'(dataOk_o),      32'(e.ok));
      chk("drop_o",        32'(drop_o),        32'(e.drop));
      chk("outstanding_o", 32'(outstanding_o), 32'(e.out));
`ifdef FETCH_PERF_CNT_EN
      chk("perf_issue_o",  perf_issue_o,       e.pi);
      chk("perf_drop_o",   perf_drop_o,        e.pd);
`endif
      if (request_o && req_ready_i) issue_log.push_back(instAddr_o);
      if (drop_o) dut_drops++;
      if (dataOk_o) dut_oks++;
    end
  end

  initial begin
    int d0, o0;
    reset_n = 1'b0;
    stall_i = 0; jumpFlag_i = 0; jumpAddr_i = '0; req_ready_i = 0; dataOk_i = 0;
    @(posedge clk); #1;

    // T1/T2: startup addresses, fill to the limit, response frees a slot same cycle
    reset_dut(2);
    issue_log.delete();
    drive(0, 0, '0, 1, 0);
    repeat (4) drive(0, 0, '0, 1, 0);
    chk("t1_issues", 32'(issue_log.size()), 32'd4);
    if (issue_log.size() >= 3) begin
      chk("t1_addr0", issue_log[0], 32'h8000_0004);
      chk("t1_addr1", issue_log[1], 32'h8000_000C);
      chk("t1_addr2", issue_log[2], 32'h8000_0014);
    end
    drive(0, 0, '0, 1, 1);
    chk("t2_refill", 32'(issue_log.size()), 32'd5);
    repeat (3) drive(0, 0, '0, 1, 0);
    chk("t2_full_hold", 32'(issue_log.size()), 32'd5);
    chk("t2_outstanding", 32'(outstanding_o), 32'd4);
    repeat (4) drive(0, 0, '0, 0, 1);

    // T3: pending request held while memory is not ready
    reset_dut(1);
    issue_log.delete();
    drive(0, 0, '0, 1, 0);
    repeat (3) drive(0, 0, '0, 0, 0);
    chk("t3_no_issue", 32'(issue_log.size()), 32'd0);
    drive(0, 0, '0, 1, 0);
    if (issue_log.size() == 1) chk("t3_addr", issue_log[0], 32'h8000_0004);
    else chk("t3_issue_count", 32'(issue_log.size()), 32'd1);

    // T4: redirect with three in flight
    reset_dut(1);
    issue_log.delete();
    drive(0, 0, '0, 1, 0);
    repeat (3) drive(0, 0, '0, 1, 0);
    drive(0, 1, 32'h8000_1006, 1, 0);
    drive(0, 0, '0, 1, 0);
    if (issue_log.size() > 0) chk("t4_target", issue_log[$], 32'h8000_1004);
    d0 = dut_drops; o0 = dut_oks;
    repeat (4) drive(0, 0, '0, 0, 1);
    chk("t4_drops", 32'(dut_drops - d0), 32'd3);
    chk("t4_oks",   32'(dut_oks - o0),   32'd1);

    // T5: redirect in the same cycle as a response
    reset_dut(1);
    drive(0, 0, '0, 1, 0);
    repeat (2) drive(0, 0, '0, 1, 0);
    d0 = dut_drops; o0 = dut_oks;
    drive(0, 1, 32'h8000_2000, 1, 1);
    drive(0, 0, '0, 0, 1);
    chk("t5_oks",   32'(dut_oks - o0),   32'd1);
    chk("t5_drops", 32'(dut_drops - d0), 32'd1);

    // T6: stall mid-stream
    reset_dut(1);
    issue_log.delete();
    drive(0, 0, '0, 1, 0);
    repeat (2) drive(0, 0, '0, 1, 0);
    repeat (5) drive(1, 0, '0, 1, 0);
    chk("t6_stalled", 32'(issue_log.size()), 32'd2);
    repeat (2) drive(0, 0, '0, 1, 0);
    if (issue_log.size() == 3) chk("t6_resume", issue_log[2], 32'h8000_0014);
    else chk("t6_issue_count", 32'(issue_log.size()), 32'd3);

    // Randomised traffic with occasional mid-operation reset
    for (int i = 0; i < 3000; i++) begin
      if ((i % 700) == 699) reset_dut(1 + int'($urandom_range(0, 2)));
      drive(($urandom % 8) == 0, ($urandom % 16) == 0, $urandom,
            ($urandom % 4) != 0, ($urandom % 3) == 0);
    end

    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
